lcd_text_line_overlay: RTL and testbench
========================================

Name: lcd_text_line_overlay

Overview:
- Renders one line of N_CHARS glyphs (CHAR_W x CHAR_H, integer SCALE) from an external synchronous glyph ROM onto the LCD pixel stream.
- Sits between the LCD timing generator (ready_sig, column/row address) and the RGB pins.
- Character codes, position and colours are written into a shadow set and committed atomically at frame start, so the display never tears.
- Fixed 3-cycle pixel latency; the aligned valid is output as pix_valid.

Parameters:
- N_CHARS, 16: characters in the line (power of two, 2..64).
- CHAR_W, 8: glyph width in pixels (power of two); also the rom_data width.
- CHAR_H, 20: glyph height in rows.
- SCALE, 1: pixel replication factor, 1, 2 or 4.
- CODE_W, 6: character code width.
- ROM_AW, 11: ROM address width; must be >= clog2(2^CODE_W * CHAR_H).
- DEF_X, 240: reset X position.
- DEF_Y, 136: reset Y position.
- DEF_FG, 24'hff00ff: reset foreground colour.
- BLANK_CODE, 0: reset code of every character slot.

Ports:
- clk  in  1  pixel clock
- rstn  in  1  asynchronous, active-low reset
- ready_sig  in  1  active-area flag from the timing generator
- column_addr_sig  in  11  current pixel column
- row_addr_sig  in  11  current pixel row
- wr_en  in  1  shadow character write strobe
- wr_idx  in  clog2(N_CHARS)  character slot to write
- wr_code  in  CODE_W  character code
- pos_x  in  11  shadow X origin, sampled on commit
- pos_y  in  11  shadow Y origin, sampled on commit
- fg_color  in  24  foreground RGB888, sampled on commit
- bg_color  in  24  background RGB888, sampled on commit
- opaque  in  1  1 = paint bg_color inside the text box, sampled on commit
- commit_req  in  1  single-cycle request to commit the shadow set
- commit_done  out  1  single-cycle pulse when the commit is applied
- rom_addr  out  ROM_AW  glyph row address, registered
- rom_data  in  CHAR_W  glyph row; valid one cycle after rom_addr, MSB = leftmost pixel
- red_sig  out  8  red output, registered
- green_sig  out  8  green output, registered
- blue_sig  out  8  blue output, registered
- pix_valid  out  1  ready_sig delayed by 3 cycles

Behaviour:
- Reset:
  - All RGB outputs, rom_addr, pix_valid and commit_done are 0.
  - Every shadow and active slot holds BLANK_CODE.
  - Active position is DEF_X/DEF_Y, fg = DEF_FG, bg = 0, opaque = 0, commit pending flag = 0.
- Reset can assert asynchronously at any time, including mid-frame or mid-commit. It clears the pipeline and both buffers immediately; no partial commit survives.
- Geometry, using the active set. All comparisons and sums are 12-bit, so X + span cannot wrap; text beyond the screen is simply clipped.
  - span_x = N_CHARS*CHAR_W*SCALE, span_y = CHAR_H*SCALE.
  - in_box = ready_sig && col in [X, X+span_x) && row in [Y, Y+span_y).
  - dx = col - X, dy = row - Y.
  - Character index = dx >> log2(CHAR_W*SCALE).
  - Bit index = (dx >> log2(SCALE)) mod CHAR_W.
  - Glyph row = dy >> log2(SCALE).
- Pipeline, with t0 = the cycle the coordinates are presented:
  - Edge t0->t1: rom_addr <= code*CHAR_H + glyph row, where code = active_buf[index]. in_box, bit index and ready_sig advance to stage 1. When in_box = 0, rom_addr holds its previous value.
  - t2: rom_data is valid; stage 2 carries in_box, bit index and ready.
  - Edge t2->t3: RGB is registered as follows.
    - in_box && rom_data[CHAR_W-1-bit] set: RGB = fg.
    - Otherwise in_box && opaque: RGB = bg.
    - Otherwise: RGB = 0.
  - pix_valid at t3 = ready_sig at t0.
- Shadow writes:
  - wr_en writes wr_code into shadow slot wr_idx on the clock edge.
  - A write with wr_idx >= N_CHARS is ignored.
  - Writes never affect the active set directly.
- Commit state machine, states IDLE and PENDING:
  - IDLE -> PENDING on commit_req.
  - frame_start = ready_sig && col == 0 && row == 0.
  - In PENDING at frame_start, on that edge: copy all shadow slots plus pos/fg/bg/opaque into the active set, pulse commit_done for one cycle, return to IDLE.
  - The frame_start pixel itself renders with the pre-commit set.
- Commit boundary cases:
  - commit_req while already PENDING is absorbed; only one commit_done is produced.
  - commit_req in the frame_start cycle while IDLE sets PENDING; it applies at the next frame start, not the current one.
  - A wr_en in the same cycle as the copy updates the shadow only. The active slot takes the pre-write shadow value.
- No output depends on rom_data outside a stage-2 in_box cycle.

Decomposition:
- Shared package lcd_pkg:
  - COORD_W = 11 and RGB_W = 24.
  - clog2 function.
  - Commit state encoding (IDLE, PENDING).
  - Function rgb_split returning the 8-bit channels.
- Natural sub-module: lcd_text_buffer. It holds the shadow and active code arrays plus the commit FSM and exposes a combinational read by index. The top module keeps the geometry, pipeline and colour select.

Test Plan:
- Reset, then scan a full 800x480 frame -> RGB is 0 everywhere; rom_addr is only ever 0*20 + row (BLANK_CODE = 0); pix_valid tracks ready_sig 3 cycles late.
- Write code 5 to slot 2, commit, glyph row pattern 8'hA5 -> at X = 240+16..23, Y = 136 the output reads ff00ff,0,ff00ff,0,0,ff00ff,0,ff00ff (3 cycles late); rom_addr = 100 at the first column of slot 2.
- Commit with opaque = 1, bg = 24'h0000ff -> zero glyph bits inside the box are 0000ff; pixels at X-1 and X+128 are 0.
- SCALE = 2 build -> each glyph bit covers a 2x2 pixel block; the box spans 256x40.
- Write slot 3 mid-frame with no commit -> output unchanged. commit_req coincident with frame_start -> commit_done one frame later, exactly one pulse. wr_en in the copy cycle -> the active slot keeps the old shadow value.
- Assert rstn low mid-line with PENDING set -> all outputs 0 at once; after release no commit_done, defaults restored; wr_idx = N_CHARS write is ignored.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and helpers for the LCD text-line overlay.
// Coordinate/colour widths, commit states, channel split.
package lcd_pkg;

  localparam int COORD_W = 11;
  localparam int RGB_W   = 24;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } commit_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic rgb_t rgb_split(input logic [RGB_W-1:0] c);
    rgb_t o;
    o.r = c[23:16];
    o.g = c[15:8];
    o.b = c[7:0];
    return o;
  endfunction

endpackage

// File: rtl/lcd_text_buffer.sv
// Shadow/active character code arrays and the commit FSM.
// The active array only changes at a frame start after a request.
module lcd_text_buffer
  import lcd_pkg::*;
#(
  parameter int N_CHARS    = 16,
  parameter int CODE_W     = 6,
  parameter int BLANK_CODE = 0,
  parameter int IW         = clog2(N_CHARS) + 1,
  parameter int RW         = clog2(N_CHARS)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_en,
  input  logic [IW-1:0]     wr_idx,
  input  logic [CODE_W-1:0] wr_code,
  input  logic              commit_req,
  input  logic              frame_start,
  input  logic [RW-1:0]     rd_idx,
  output logic [CODE_W-1:0] rd_code,
  output logic              copy,
  output logic              commit_done
);

  commit_state_t state, state_n;
  logic [CODE_W-1:0] shadow [N_CHARS];
  logic [CODE_W-1:0] active [N_CHARS];
  logic wr_ok;

  assign wr_ok   = wr_en && (wr_idx < IW'(N_CHARS));
  assign rd_code = active[rd_idx];

  always_comb begin
    state_n = state;
    copy    = 1'b0;
    unique case (state)
      IDLE:    if (commit_req) state_n = PENDING;
      PENDING: if (frame_start) begin
        state_n = IDLE;
        copy    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      commit_done <= 1'b0;
    end else begin
      state       <= state_n;
      commit_done <= copy;
    end
  end

  // Non-blocking copy: a same-edge write lands in shadow only.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_CHARS; i++) begin
        shadow[i] <= CODE_W'(BLANK_CODE);
        active[i] <= CODE_W'(BLANK_CODE);
      end
    end else begin
      if (copy)
        for (int i = 0; i < N_CHARS; i++)
          active[i] <= shadow[i];
      if (wr_ok)
        shadow[wr_idx[RW-1:0]] <= wr_code;
    end
  end

endmodule

// File: rtl/lcd_text_line_overlay.sv
// One line of ROM glyphs overlaid on the LCD pixel stream.
// Three-stage pipeline: ROM address, ROM data, colour select.
module lcd_text_line_overlay
  import lcd_pkg::*;
#(
  parameter int          N_CHARS    = 16,
  parameter int          CHAR_W     = 8,
  parameter int          CHAR_H     = 20,
  parameter int          SCALE      = 1,
  parameter int          CODE_W     = 6,
  parameter int          ROM_AW     = 11,
  parameter int          DEF_X      = 240,
  parameter int          DEF_Y      = 136,
  parameter logic [23:0] DEF_FG     = 24'hff00ff,
  parameter int          BLANK_CODE = 0
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     ready_sig,
  input  logic [10:0]              column_addr_sig,
  input  logic [10:0]              row_addr_sig,
  input  logic                     wr_en,
  input  logic [clog2(N_CHARS):0]  wr_idx,
  input  logic [CODE_W-1:0]        wr_code,
  input  logic [10:0]              pos_x,
  input  logic [10:0]              pos_y,
  input  logic [23:0]              fg_color,
  input  logic [23:0]              bg_color,
  input  logic                     opaque,
  input  logic                     commit_req,
  output logic                     commit_done,
  output logic [ROM_AW-1:0]        rom_addr,
  input  logic [CHAR_W-1:0]        rom_data,
  output logic [7:0]               red_sig,
  output logic [7:0]               green_sig,
  output logic [7:0]               blue_sig,
  output logic                     pix_valid
);

  localparam int RW  = clog2(N_CHARS);
  localparam int BW  = clog2(CHAR_W);
  localparam int SSH = clog2(SCALE);
  localparam int CSH = clog2(CHAR_W * SCALE);
  localparam logic [11:0] SPAN_X = 12'(N_CHARS * CHAR_W * SCALE);
  localparam logic [11:0] SPAN_Y = 12'(CHAR_H * SCALE);

  logic [COORD_W-1:0] act_x, act_y;
  logic [RGB_W-1:0]   act_fg, act_bg;
  logic               act_op, copy, frame_start, in_box, glyph;
  logic [11:0]        col, row, x0, y0, dx, dy;
  logic [RW-1:0]      rd_idx;
  logic [CODE_W-1:0]  rd_code;
  logic [BW-1:0]      bit_n, s1_bit, s2_bit;
  logic [ROM_AW-1:0]  addr_n;
  logic               s1_in, s2_in, s1_rdy, s2_rdy;
  logic [RGB_W-1:0]   s1_fg, s1_bg, s2_fg, s2_bg;
  logic [RGB_W-1:0]   rgb_q, rgb_n;
  rgb_t               px;

  assign frame_start = ready_sig && (column_addr_sig == '0)
                       && (row_addr_sig == '0);

  // 12-bit geometry so the box end never wraps.
  assign col    = {1'b0, column_addr_sig};
  assign row    = {1'b0, row_addr_sig};
  assign x0     = {1'b0, act_x};
  assign y0     = {1'b0, act_y};
  assign dx     = col - x0;
  assign dy     = row - y0;
  assign in_box = ready_sig
                  && (col >= x0) && (col < x0 + SPAN_X)
                  && (row >= y0) && (row < y0 + SPAN_Y);
  assign rd_idx = RW'(dx >> CSH);
  assign bit_n  = BW'(dx >> SSH);
  assign addr_n = ROM_AW'(rd_code) * ROM_AW'(CHAR_H)
                  + ROM_AW'(dy >> SSH);

  lcd_text_buffer #(
    .N_CHARS    (N_CHARS),
    .CODE_W     (CODE_W),
    .BLANK_CODE (BLANK_CODE)
  ) u_buf (
    .clk         (clk),
    .rstn        (rstn),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_code     (wr_code),
    .commit_req  (commit_req),
    .frame_start (frame_start),
    .rd_idx      (rd_idx),
    .rd_code     (rd_code),
    .copy        (copy),
    .commit_done (commit_done)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      act_x  <= COORD_W'(DEF_X);
      act_y  <= COORD_W'(DEF_Y);
      act_fg <= DEF_FG;
      act_bg <= '0;
      act_op <= 1'b0;
    end else if (copy) begin
      act_x  <= pos_x;
      act_y  <= pos_y;
      act_fg <= fg_color;
      act_bg <= bg_color;
      act_op <= opaque;
    end
  end

  // Colours ride with the pixel so a commit never splits one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rom_addr <= '0;
      s1_in    <= 1'b0;
      s1_bit   <= '0;
      s1_rdy   <= 1'b0;
      s1_fg    <= '0;
      s1_bg    <= '0;
      s2_in    <= 1'b0;
      s2_bit   <= '0;
      s2_rdy   <= 1'b0;
      s2_fg    <= '0;
      s2_bg    <= '0;
      rgb_q    <= '0;
      pix_valid <= 1'b0;
    end else begin
      if (in_box) rom_addr <= addr_n;
      s1_in    <= in_box;
      s1_bit   <= bit_n;
      s1_rdy   <= ready_sig;
      s1_fg    <= act_fg;
      s1_bg    <= act_op ? act_bg : '0;
      s2_in    <= s1_in;
      s2_bit   <= s1_bit;
      s2_rdy   <= s1_rdy;
      s2_fg    <= s1_fg;
      s2_bg    <= s1_bg;
      rgb_q    <= rgb_n;
      pix_valid <= s2_rdy;
    end
  end

  assign glyph = s2_in && rom_data[BW'(CHAR_W - 1) - s2_bit];

  always_comb begin
    rgb_n = '0;
    if (glyph)      rgb_n = s2_fg;
    else if (s2_in) rgb_n = s2_bg;
  end

  assign px        = rgb_split(rgb_q);
  assign red_sig   = px.r;
  assign green_sig = px.g;
  assign blue_sig  = px.b;

endmodule

// File: tb/tb_lcd_text_line_overlay.sv
// Bench: SCALE 1 and SCALE 2 overlays against a reference model.
// Directed commit/reset cases, then randomized pixels and writes.
module tb_lcd_text_line_overlay;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  logic        ready;
  logic [10:0] col, row;
  logic        wr_en;
  logic [4:0]  wr_idx;
  logic [5:0]  wr_code;
  logic [10:0] pos_x, pos_y;
  logic [23:0] fg, bg;
  logic        opaque, creq;

  logic        done1, done2, v1, v2;
  logic [10:0] addr1, addr2;
  logic [7:0]  data1, data2;
  logic [7:0]  r1, g1, b1, r2, g2, b2;

  logic [7:0] rom [2048];
  always @(posedge clk) begin
    data1 <= rom[addr1];
    data2 <= rom[addr2];
  end

  lcd_text_line_overlay u1 (
    .clk(clk), .rstn(rstn), .ready_sig(ready),
    .column_addr_sig(col), .row_addr_sig(row),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_code(wr_code),
    .pos_x(pos_x), .pos_y(pos_y), .fg_color(fg), .bg_color(bg),
    .opaque(opaque), .commit_req(creq), .commit_done(done1),
    .rom_addr(addr1), .rom_data(data1),
    .red_sig(r1), .green_sig(g1), .blue_sig(b1), .pix_valid(v1)
  );

  lcd_text_line_overlay #(.SCALE(2)) u2 (
    .clk(clk), .rstn(rstn), .ready_sig(ready),
    .column_addr_sig(col), .row_addr_sig(row),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_code(wr_code),
    .pos_x(pos_x), .pos_y(pos_y), .fg_color(fg), .bg_color(bg),
    .opaque(opaque), .commit_req(creq), .commit_done(done2),
    .rom_addr(addr2), .rom_data(data2),
    .red_sig(r2), .green_sig(g2), .blue_sig(b2), .pix_valid(v2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int          m_sh [16];
  int          m_act [16];
  int          ax, ay;
  logic [23:0] afg, abg;
  bit          aop, pend;
  int          maddr [2];
  logic [23:0] e_rgb [2][8];
  bit          e_v [2][8];
  int          k;
  int          pulses;
  logic [23:0] got_rgb [1024];
  logic [10:0] got_addr [1024];

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_sh[i] = 0;
      m_act[i] = 0;
    end
    ax = 240; ay = 136; afg = 24'hff00ff; abg = 0;
    aop = 0; pend = 0;
    maddr[0] = 0; maddr[1] = 0;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 8; i++) begin
        e_rgb[s][i] = 0;
        e_v[s][i] = 0;
      end
    k = 8;
  endtask

  task automatic pix(input int s, output bit inb, output int addr,
                     output logic [23:0] c);
    int dx, dy, idx, b;
    logic [7:0] g;
    dx = int'(col) - ax;
    dy = int'(row) - ay;
    inb = ready && dx >= 0 && dx < 128 * s && dy >= 0 && dy < 20 * s;
    addr = 0;
    c = 0;
    if (inb) begin
      idx = dx / (8 * s);
      b = (dx / s) % 8;
      addr = m_act[idx] * 20 + dy / s;
      g = rom[addr];
      if (g[7 - b]) c = afg;
      else if (aop) c = abg;
    end
  endtask

  task automatic step(input bit r, input int c, input int w);
    bit inb, fs, cp;
    int a;
    logic [23:0] px;
    ready = r;
    col = 11'(c);
    row = 11'(w);
    for (int s = 0; s < 2; s++) begin
      pix(s + 1, inb, a, px);
      e_rgb[s][k % 8] = px;
      e_v[s][k % 8] = r;
      if (inb) maddr[s] = a;
    end
    fs = r && col == 0 && row == 0;
    cp = pend && fs;
    pend = pend ? !fs : creq;
    if (cp) begin
      for (int i = 0; i < 16; i++) m_act[i] = m_sh[i];
      ax = int'(pos_x); ay = int'(pos_y);
      afg = fg; abg = bg; aop = opaque;
    end
    if (wr_en && wr_idx < 16) m_sh[wr_idx] = int'(wr_code);
    @(posedge clk);
    #1;
    if (done1) pulses++;
    chk("done1", done1, cp);
    chk("done2", done2, cp);
    chk("addr1", addr1, maddr[0]);
    chk("addr2", addr2, maddr[1]);
    chk("rgb1", {r1, g1, b1}, e_rgb[0][(k + 6) % 8]);
    chk("rgb2", {r2, g2, b2}, e_rgb[1][(k + 6) % 8]);
    chk("val1", v1, e_v[0][(k + 6) % 8]);
    chk("val2", v2, e_v[1][(k + 6) % 8]);
    got_rgb[(k + 1022) % 1024] = {r1, g1, b1};
    got_addr[k % 1024] = addr1;
    k++;
  endtask

  task automatic flush();
    for (int i = 0; i < 3; i++) step(0, 5, 5);
  endtask

  task automatic do_commit();
    creq = 1;
    step(0, 5, 5);
    creq = 0;
    step(1, 0, 0);
    step(0, 5, 5);
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_rgb1"}, {r1, g1, b1}, 0);
    chk({tag, "_rgb2"}, {r2, g2, b2}, 0);
    chk({tag, "_v"}, {v1, v2}, 0);
    chk({tag, "_done"}, {done1, done2}, 0);
    chk({tag, "_addr1"}, addr1, 0);
    chk({tag, "_addr2"}, addr2, 0);
  endtask

  int c0, p0;
  logic [23:0] a5_exp [8];

  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
    for (int i = 0; i < 20; i++) rom[i] = 8'h00;
    rom[100] = 8'hA5;
    ready = 0; col = 0; row = 0;
    wr_en = 0; wr_idx = 0; wr_code = 0;
    pos_x = 240; pos_y = 136; fg = 24'hff00ff; bg = 0;
    opaque = 0; creq = 0; pulses = 0;
    model_reset();

    #1 rstn = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_zero_outs("reset");
    @(negedge clk);
    rstn = 1;

    // Blank text: black everywhere, addr is code 0 rows
    for (int w = 134; w < 160; w += 3)
      for (int c = 236; c < 374; c++) step(1, c, w);
    c0 = k;
    step(1, 240, 150);
    flush();
    chk("blank_addr", got_addr[c0 % 1024], 14);
    chk("blank_rgb", got_rgb[c0 % 1024], 0);

    // Code 5 in slot 2 with glyph row A5
    wr_en = 1; wr_idx = 2; wr_code = 5;
    step(0, 5, 5);
    wr_en = 0;
    p0 = pulses;
    do_commit();
    chk("commit_pulse", pulses - p0, 1);
    a5_exp = '{24'hff00ff, 0, 24'hff00ff, 0, 0, 24'hff00ff, 0, 24'hff00ff};
    c0 = k;
    for (int i = 0; i < 8; i++) step(1, 256 + i, 136);
    flush();
    chk("a5_addr", got_addr[c0 % 1024], 100);
    for (int i = 0; i < 8; i++)
      chk("a5_px", got_rgb[(c0 + i) % 1024], a5_exp[i]);

    // Opaque background and box edges
    bg = 24'h0000ff; opaque = 1;
    do_commit();
    c0 = k;
    step(1, 239, 136);
    step(1, 368, 136);
    step(1, 257, 136);
    step(1, 256, 136);
    flush();
    chk("edge_left", got_rgb[c0 % 1024], 0);
    chk("edge_right", got_rgb[(c0 + 1) % 1024], 0);
    chk("opaque_bg", got_rgb[(c0 + 2) % 1024], 24'h0000ff);
    chk("opaque_fg", got_rgb[(c0 + 3) % 1024], 24'hff00ff);

    // Shadow write without commit leaves slot 3 blank
    wr_en = 1; wr_idx = 3; wr_code = 9;
    step(1, 264, 136);
    wr_en = 0;
    c0 = k;
    step(1, 264, 136);
    flush();
    chk("no_commit", got_addr[c0 % 1024], 0);

    // Request in the frame-start cycle waits a frame
    p0 = pulses;
    creq = 1;
    step(1, 0, 0);
    creq = 0;
    for (int i = 0; i < 4; i++) step(1, 300 + i, 140);
    chk("fs_same", pulses - p0, 0);
    creq = 1;
    step(1, 301, 140);
    creq = 0;
    step(1, 0, 0);
    step(0, 5, 5);
    chk("fs_next", pulses - p0, 1);

    // Write in the copy cycle goes to shadow only
    creq = 1;
    step(0, 5, 5);
    creq = 0;
    wr_en = 1; wr_idx = 2; wr_code = 7;
    step(1, 0, 0);
    wr_en = 0;
    c0 = k;
    step(1, 256, 136);
    flush();
    chk("copy_wr_old", got_addr[c0 % 1024], 100);
    do_commit();
    c0 = k;
    step(1, 256, 136);
    flush();
    chk("copy_wr_new", got_addr[c0 % 1024], 140);

    // Async reset mid-line with a commit pending
    creq = 1;
    step(0, 5, 5);
    creq = 0;
    step(1, 256, 136);
    step(1, 257, 136);
    #2 rstn = 0;
    #1;
    chk_zero_outs("async_rst");
    @(posedge clk);
    @(negedge clk);
    rstn = 1;
    model_reset();
    pos_x = 240; pos_y = 136; fg = 24'hff00ff; bg = 0; opaque = 0;
    p0 = pulses;
    wr_en = 1; wr_idx = 16; wr_code = 9;
    step(1, 0, 0);
    wr_en = 0;
    step(0, 5, 5);
    chk("rst_no_done", pulses - p0, 0);
    do_commit();
    c0 = k;
    step(1, 240, 136);
    step(1, 256, 136);
    flush();
    chk("idx16_ignored", got_addr[c0 % 1024], 0);
    chk("rst_defaults", got_addr[(c0 + 1) % 1024], 0);

    // Randomized traffic
    for (int i = 0; i < 12000; i++) begin
      wr_en = ($urandom % 4) == 0;
      wr_idx = 5'($urandom % 17);
      wr_code = 6'($urandom);
      creq = ($urandom % 60) == 0;
      if ($urandom % 200 == 0) begin
        pos_x = ($urandom % 4 == 0) ? 11'(1900 + $urandom % 148)
                                    : 11'($urandom % 700);
        pos_y = ($urandom % 4 == 0) ? 11'(2000 + $urandom % 48)
                                    : 11'($urandom % 480);
        fg = 24'($urandom);
        bg = 24'($urandom);
        opaque = 1'($urandom);
      end
      if ($urandom % 80 == 0)
        step(1, 0, 0);
      else
        step($urandom % 8 != 0,
             (ax + int'($urandom_range(0, 300)) - 20) & 2047,
             (ay + int'($urandom_range(0, 50)) - 5) & 2047);
    end
    wr_en = 0;
    creq = 0;
    flush();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
